// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter sharing one line-wide data-memory port
// between the instruction cache (port 0) and the data cache (port 1).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic [LINE_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state, state_d;
  logic                prio, prio_d;
  logic                mem_enable_d, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [LINE_W-1:0]   mem_data_d;
  logic [LINE_W-1:0]   m0_data_d, m1_data_d;
  logic                m0_ack_d, m1_ack_d;

  assign busy_o = (state != IDLE);

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d      = state;
    prio_d       = prio;
    mem_enable_d = mem_enable_o;
    mem_write_d  = mem_write_o;
    mem_addr_d   = mem_addr_o;
    mem_data_d   = mem_data_o;
    m0_data_d    = m0_data_o;
    m1_data_d    = m1_data_o;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    unique case (state)
      IDLE: begin
        // Port 0 wins when alone or when both request and it holds priority.
        if (m0_enable_i && (!m1_enable_i || !prio)) begin
          state_d      = GRANT0;
          mem_enable_d = 1'b1;
          mem_write_d  = m0_write_i;
          mem_addr_d   = m0_addr_i;
          mem_data_d   = m0_data_i;
        end else if (m1_enable_i) begin
          state_d      = GRANT1;
          mem_enable_d = 1'b1;
          mem_write_d  = m1_write_i;
          mem_addr_d   = m1_addr_i;
          mem_data_d   = m1_data_i;
        end
      end
      GRANT0: begin
        if (mem_ack_i) begin
          state_d      = RELEASE;
          mem_enable_d = 1'b0;
          m0_ack_d     = 1'b1;
          prio_d       = 1'b1;
          if (!mem_write_o) m0_data_d = mem_data_i;
        end
      end
      GRANT1: begin
        if (mem_ack_i) begin
          state_d      = RELEASE;
          mem_enable_d = 1'b0;
          m1_ack_d     = 1'b1;
          prio_d       = 1'b0;
          if (!mem_write_o) m1_data_d = mem_data_i;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      prio         <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      m0_data_o    <= '0;
      m1_data_o    <= '0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
    end else begin
      state        <= state_d;
      prio         <= prio_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      m0_data_o    <= m0_data_d;
      m1_data_o    <= m1_data_d;
      m0_ack_o     <= m0_ack_d;
      m1_ack_o     <= m1_ack_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [LINE_W-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic              m0_ack_o, m1_ack_o;
  logic              mem_enable_o, mem_write_o, mem_ack_i, busy_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o, mem_data_i;

  int checks = 0;
  int fails  = 0;

  logic [LINE_W-1:0] line_a5, line_l1, line_l2, line_l3, line_l4;

  dmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Both acks must never be high together while out of reset.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      checks++;
      assert (!(m0_ack_o && m1_ack_o)) else begin
        fails++;
        $error("FAIL dual_ack observed=%b%b expected=not both", m0_ack_o, m1_ack_o);
      end
    end
  end

  initial begin
    line_a5 = {32{8'hA5}};
    line_l1 = {8{32'h1111_0001}};
    line_l2 = {8{32'h2222_0002}};
    line_l3 = {8{32'h3333_0003}};
    line_l4 = {8{32'h4444_0004}};
    rst_i = 1'b0;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;

    // Reset state
    #3;
    check("rst_busy", busy_o, 0);
    check("rst_mem_en", mem_enable_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_m0_data", m0_data_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // Port 0 read 0x400, memory acks three cycles after enable
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400;
    tick();
    check("t1_mem_en", mem_enable_o, 1);
    check("t1_mem_addr", mem_addr_o, 32'h400);
    check("t1_mem_wr", mem_write_o, 0);
    check("t1_busy", busy_o, 1);
    tick(); tick();
    check("t1_no_early_ack", m0_ack_o, 0);
    mem_ack_i = 1'b1; mem_data_i = line_a5;
    tick();
    check("t1_m0_ack", m0_ack_o, 1);
    check("t1_m1_ack", m1_ack_o, 0);
    check("t1_m0_data", m0_data_o, line_a5);
    check("t1_mem_en_clr", mem_enable_o, 0);
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    tick();
    check("t1_ack_pulse", m0_ack_o, 0);
    check("t1_idle", busy_o, 0);

    // Stray memory ack in IDLE is ignored
    mem_ack_i = 1'b1;
    tick();
    check("stray_ack_busy", busy_o, 0);
    check("stray_ack_acks", {m0_ack_o, m1_ack_o}, 0);
    mem_ack_i = 1'b0;

    // Port 1 write 0x820; inputs wander during GRANT1
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_0820; m1_data_i = 256'h1234;
    tick();
    check("t2_mem_wr", mem_write_o, 1);
    check("t2_mem_addr", mem_addr_o, 32'h820);
    check("t2_mem_data", mem_data_o, 256'h1234);
    m1_addr_i = 32'hFFFF_FFE0; m1_data_i = 256'hDEAD; m1_write_i = 1'b0;
    tick();
    check("t2_hold_addr", mem_addr_o, 32'h820);
    check("t2_hold_data", mem_data_o, 256'h1234);
    check("t2_hold_wr", mem_write_o, 1);
    mem_ack_i = 1'b1; mem_data_i = 256'h5555;
    tick();
    check("t2_m1_ack", m1_ack_o, 1);
    check("t2_m0_ack", m0_ack_o, 0);
    check("t2_m1_data_kept", m1_data_o, 0);
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick();
    check("t2_ack_pulse", m1_ack_o, 0);

    // Simultaneous requests: prio is back to port 0
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h100;
    m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h200;
    tick();
    check("t3_first_p0", mem_addr_o, 32'h100);
    mem_ack_i = 1'b1; mem_data_i = line_l1;
    tick();
    check("t3_m0_ack", m0_ack_o, 1);
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    tick();
    check("t3_release_gap", mem_enable_o, 0);
    tick();
    check("t3_p1_grant_en", mem_enable_o, 1);
    check("t3_p1_grant_addr", mem_addr_o, 32'h200);
    mem_ack_i = 1'b1; mem_data_i = line_l2;
    tick();
    check("t3_m1_ack", m1_ack_o, 1);
    check("t3_m1_data", m1_data_o, line_l2);
    check("t3_m0_data_kept", m0_data_o, line_l1);
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick();
    m0_enable_i = 1'b1; m0_addr_i = 32'h300;
    m1_enable_i = 1'b1; m1_addr_i = 32'h340;
    tick();
    check("t3_second_p0", mem_addr_o, 32'h300);
    mem_ack_i = 1'b1;
    tick();
    check("t3_second_m0_ack", m0_ack_o, 1);
    mem_ack_i = 1'b0; m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    tick(); tick();

    // Port 1 write-back then refill with port 0 waiting (prio now port 1)
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h500; m1_data_i = 256'hBEEF;
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h600;
    tick();
    check("t4_wb_addr", mem_addr_o, 32'h500);
    check("t4_wb_wr", mem_write_o, 1);
    mem_ack_i = 1'b1;
    tick();
    check("t4_wb_ack", m1_ack_o, 1);
    mem_ack_i = 1'b0; m1_write_i = 1'b0;
    tick();
    check("t4_gap1_a", mem_enable_o, 0);
    tick();
    check("t4_p0_en", mem_enable_o, 1);
    check("t4_p0_addr", mem_addr_o, 32'h600);
    mem_ack_i = 1'b1; mem_data_i = line_l3;
    tick();
    check("t4_p0_ack", m0_ack_o, 1);
    check("t4_gap2_b", mem_enable_o, 0);
    check("t4_p0_data", m0_data_o, line_l3);
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    tick();
    check("t4_gap2_a", mem_enable_o, 0);
    tick();
    check("t4_refill_addr", mem_addr_o, 32'h500);
    check("t4_refill_wr", mem_write_o, 0);
    mem_ack_i = 1'b1; mem_data_i = line_l4;
    tick();
    check("t4_refill_ack", m1_ack_o, 1);
    check("t4_refill_data", m1_data_o, line_l4);
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick(); tick();

    // Asynchronous reset during GRANT0 abandons the access
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h700;
    tick();
    check("t5_granted", mem_enable_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("t5_mem_en", mem_enable_o, 0);
    check("t5_mem_addr", mem_addr_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_m0_data", m0_data_o, 0);
    check("t5_m1_data", m1_data_o, 0);
    m0_enable_i = 1'b0;
    mem_ack_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    check("t5_no_ack", {m0_ack_o, m1_ack_o}, 0);
    check("t5_idle", busy_o, 0);
    mem_ack_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single 256-bit data-memory port between the instruction cache (port 0) and the data cache (port 1).
- Sits between both cache controllers and the data memory model.
- Captures one line request at a time, holds it stable to memory until acknowledged, and returns the acknowledge and read line to the winner.
- Round-robin priority prevents either cache from starving the other.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
m0_enable_i  in  1  port 0 request, held high until m0_ack_o
m0_write_i  in  1  port 0 write (1) / read (0)
m0_addr_i  in  ADDR_W  port 0 line address (bits [4:0] zero)
m0_data_i  in  LINE_W  port 0 write line
m0_data_o  out  LINE_W  port 0 read line
m0_ack_o  out  1  port 0 completion pulse
m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o  same as port 0, for port 1
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory line address
mem_data_o  out  LINE_W  memory write line
mem_data_i  in  LINE_W  memory read line
mem_ack_i  in  1  memory completion
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i low, async): state=IDLE; prio=0 (port 0 preferred); all outputs 0, including mX_data_o, mem_addr_o and mem_data_o.
- States: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE:
  - If exactly one enable is high, go to GRANTx for that port.
  - If both are high, grant port prio.
  - On the grant edge, latch the winner's addr/write/data into the outgoing registers and set mem_enable_o=1.
  - If neither is high, stay in IDLE.
- GRANTx:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are held from the latched registers, independent of the requester inputs.
  - Wait for mem_ack_i; no timeout.
  - On mem_ack_i=1:
    - Clear mem_enable_o.
    - If the transfer was a read, register mem_data_i into mx_data_o.
    - Set mx_ack_o=1.
    - Set prio to the other port.
    - Go to RELEASE.
- RELEASE (exactly one cycle):
  - mx_ack_o is high for this cycle only.
  - Go to IDLE. No new grant is made in this cycle.
  - This guarantees the requester has dropped or re-issued its enable before it is re-sampled.
  - mem_enable_o is low for at least this cycle between back-to-back transactions, so memory sees a fresh request edge.
- Latency: request seen in IDLE at edge N; mem_enable_o high from N; mem_ack_i at edge M; mx_ack_o and data valid in cycle M to M+1; next grant at edge M+2 at the earliest.
- mX_data_o keeps its last captured line until the next read completion for that port. Writes do not alter it.
- m0_ack_o and m1_ack_o are never high in the same cycle.
- mem_ack_i outside GRANTx is ignored.
- A requester that drops enable before its ack is a protocol violation. The arbiter still completes the latched transaction and issues the ack.
- Write-back followed by refill on port 1 (enable held continuously) counts as two transactions. If port 0 is waiting, port 0 is served between them.
- rst_i asserted mid-transaction: immediate return to reset values. The in-flight memory access is abandoned and no ack is issued.

Test Plan:
- Port 0 read 0x0000_0400, memory acks 3 cycles after enable returning line 0xA5..A5 -> mem_addr_o=0x400, mem_write_o=0; m0_ack_o one-cycle pulse the cycle after mem_ack_i; m0_data_o=0xA5..A5; m1_ack_o stays 0.
- Port 1 write 0x0000_0820 with line 0x1234 (zero-extended) -> mem_write_o=1, mem_data_o=0x1234; m1_ack_o pulses; m1_data_o unchanged.
- Both enables rise in the same cycle after reset -> port 0 served first. On port 0's RELEASE edge port 0 drops its enable; port 1 is granted at the IDLE edge that follows. A second simultaneous request is then granted to port 0 again, because prio alternates.
- Port 1 write-back then refill with enable held, port 0 requesting throughout -> order is port 1 write, port 0 read, port 1 read; mem_enable_o low for exactly 2 cycles between each.
- Requester inputs change address and data while in GRANT1 -> mem_addr_o and mem_data_o stay at the latched values until mem_ack_i.
- rst_i pulsed low during GRANT0 before mem_ack_i -> all outputs 0 asynchronously, state IDLE, and no ack is issued on either port.
